// File: rtl/sr_cond_pkg.sv
// Shared types and constants for the SR input conditioner.
package sr_cond_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE = 4;

  localparam int unsigned PRIO_CLR = 0;
  localparam int unsigned PRIO_SET = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FIRE_S   = 2'd1,
    ST_FIRE_R   = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_e;

  typedef enum logic {
    CH_SET = 1'b0,
    CH_CLR = 1'b1
  } chan_e;

endpackage

// File: rtl/sr_input_conditioner_debounce.sv
// One request channel: 2-flop synchroniser, debounce counter, stable level and
// a one-cycle rising-edge indication of the stable level.
module debounce_sync
  import sr_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_c_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          stable_prev_q;

  // Count consecutive disagreements; flip the level once the run is long enough.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q        <= 1'b0;
      sync_q        <= 1'b0;
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
    end else begin
      meta_q        <= raw_i;
      sync_q        <= meta_q;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
    end
  end

  assign stable_o = stable_q;
  assign rise_c_o = stable_q & ~stable_prev_q;

endmodule

// File: rtl/sr_input_conditioner.sv
// Conditions raw set/clear buttons into clean, mutually exclusive one-cycle
// S/R pulses with priority arbitration and release tracking.
module sr_input_conditioner
  import sr_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int unsigned SET_WINS        = PRIO_CLR
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  output logic S,
  output logic R,
  output logic set_stable,
  output logic clr_stable,
  output logic conflict,
  output logic dropped
);

  localparam bit SET_PRIO = (SET_WINS == PRIO_SET);

  logic   set_rise_c, clr_rise_c;
  logic   any_rise_c, rel_level_c;
  state_e state_q;
  chan_e  chan_q;
  logic   s_q, r_q, conflict_q, dropped_q;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_i    (set_req),
    .stable_o (set_stable),
    .rise_c_o (set_rise_c)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_i    (clr_req),
    .stable_o (clr_stable),
    .rise_c_o (clr_rise_c)
  );

  assign any_rise_c  = set_rise_c | clr_rise_c;
  assign rel_level_c = (chan_q == CH_SET) ? set_stable : clr_stable;

  // Arbitration: one pulse per accepted press, then hold off until release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      chan_q     <= CH_SET;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      dropped_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (set_rise_c && clr_rise_c) begin
            conflict_q <= 1'b1;
            if (SET_PRIO) begin
              state_q <= ST_FIRE_S;
              s_q     <= 1'b1;
            end else begin
              state_q <= ST_FIRE_R;
              r_q     <= 1'b1;
            end
          end else if (set_rise_c) begin
            state_q <= ST_FIRE_S;
            s_q     <= 1'b1;
          end else if (clr_rise_c) begin
            state_q <= ST_FIRE_R;
            r_q     <= 1'b1;
          end
        end
        ST_FIRE_S: begin
          state_q   <= ST_WAIT_REL;
          chan_q    <= CH_SET;
          dropped_q <= any_rise_c;
        end
        ST_FIRE_R: begin
          state_q   <= ST_WAIT_REL;
          chan_q    <= CH_CLR;
          dropped_q <= any_rise_c;
        end
        ST_WAIT_REL: begin
          dropped_q <= any_rise_c;
          if (!rel_level_c) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign conflict = conflict_q;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Scoreboard bench: two instances (clear-wins and set-wins) share the same
// random button stimulus and are checked against a behavioural model.
module tb_sr_input_conditioner;

  localparam int unsigned D = 4;

  typedef struct {
    int unsigned cyc;
    logic [5:0]  val;   // {S, R, conflict, dropped, set_stable, clr_stable}
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;

  logic s0, r0, ss0, cs0, cf0, dr0;
  logic s1, r1, ss1, cs1, cf1, dr1;
  logic [5:0] dut_o [2];

  int checks = 0;
  int failures = 0;
  int unsigned ecount = 0;

  ev_t sbq [2][$];
  logic [1:0] last_st [2];

  // Behavioural model state, per instance p and channel ch (0 = set, 1 = clear)
  bit         m_ff1  [2][2];
  bit         m_ff2  [2][2];
  bit         m_st   [2][2];
  bit         m_stp  [2][2];
  bit [D-1:0] m_hist [2][2];
  int         m_ph   [2];     // 0 idle, 1 pulsing, 2 waiting for release
  int         m_chan [2];
  bit         m_s_last [2];

  sr_input_conditioner #(.DEBOUNCE_CYCLES(D), .SET_WINS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
    .S(s0), .R(r0), .set_stable(ss0), .clr_stable(cs0),
    .conflict(cf0), .dropped(dr0)
  );

  sr_input_conditioner #(.DEBOUNCE_CYCLES(D), .SET_WINS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
    .S(s1), .R(r1), .set_stable(ss1), .clr_stable(cs1),
    .conflict(cf1), .dropped(dr1)
  );

  assign dut_o[0] = {s0, r0, cf0, dr0, ss0, cs0};
  assign dut_o[1] = {s1, r1, cf1, dr1, ss1, cs1};

  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_ff1[p][ch]  = 1'b0;
        m_ff2[p][ch]  = 1'b0;
        m_st[p][ch]   = 1'b0;
        m_stp[p][ch]  = 1'b0;
        m_hist[p][ch] = '0;
      end
      m_ph[p] = 0;
      m_chan[p] = 0;
      m_s_last[p] = 1'b0;
      sbq[p].delete();
    end
  endfunction

  // Advance instance p by one clock edge with the given raw inputs sampled.
  function automatic void model_step(int p, bit raw_s, bit raw_c, int unsigned tag);
    bit rs, rc, s, r, cf, dr, set_first;
    bit [D-1:0] h;
    bit old_st [2];
    ev_t e;
    rs = m_st[p][0] & ~m_stp[p][0];
    rc = m_st[p][1] & ~m_stp[p][1];
    s = 0; r = 0; cf = 0; dr = 0;
    set_first = (p == 1);
    case (m_ph[p])
      0: begin
        if (rs && rc) begin
          cf = 1;
          if (set_first) begin s = 1; m_chan[p] = 0; end
          else begin r = 1; m_chan[p] = 1; end
          m_ph[p] = 1;
        end else if (rs) begin
          s = 1; m_chan[p] = 0; m_ph[p] = 1;
        end else if (rc) begin
          r = 1; m_chan[p] = 1; m_ph[p] = 1;
        end
      end
      1: begin
        dr = rs | rc;
        m_ph[p] = 2;
      end
      default: begin
        dr = rs | rc;
        if (!m_st[p][m_chan[p]]) m_ph[p] = 0;
      end
    endcase
    for (int ch = 0; ch < 2; ch++) begin
      old_st[ch] = m_st[p][ch];
      h = {m_hist[p][ch][D-2:0], m_ff2[p][ch]};
      m_hist[p][ch] = h;
      if (!old_st[ch] && h == '1) m_st[p][ch] = 1'b1;
      else if (old_st[ch] && h == '0) m_st[p][ch] = 1'b0;
      m_stp[p][ch] = old_st[ch];
      m_ff2[p][ch] = m_ff1[p][ch];
    end
    m_ff1[p][0] = raw_s;
    m_ff1[p][1] = raw_c;
    m_s_last[p] = s;
    if (s || r || cf || dr || m_st[p][0] != old_st[0] || m_st[p][1] != old_st[1]) begin
      e.cyc = tag;
      e.val = {s, r, cf, dr, m_st[p][0], m_st[p][1]};
      sbq[p].push_back(e);
    end
  endfunction

  // Called at a falling edge: drive inputs, predict the next rising edge.
  task automatic step(input logic a, input logic b);
    set_req = a;
    clr_req = b;
    for (int p = 0; p < 2; p++) model_step(p, a, b, ecount + 1);
    @(negedge clk);
  endtask

  task automatic check_quiet(input string name);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (dut_o[p] !== 6'b0) begin
        failures++;
        $display("FAIL %s dut%0d actual=%b required=000000", name, p, dut_o[p]);
      end
    end
  endtask

  // Monitor: compare whenever a DUT shows activity or an event is due.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_st[0] = 2'b00;
      last_st[1] = 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        logic present, due;
        ev_t e;
        while (sbq[p].size() > 0 && sbq[p][0].cyc < ecount) begin
          checks++;
          failures++;
          $display("FAIL missed_event dut%0d cyc=%0d actual=none required=%b",
                   p, sbq[p][0].cyc, sbq[p][0].val);
          void'(sbq[p].pop_front());
        end
        present = (dut_o[p][5:2] != 4'b0) || (dut_o[p][1:0] != last_st[p]);
        due = (sbq[p].size() > 0) && (sbq[p][0].cyc == ecount);
        if (present || due) begin
          checks++;
          if (!due) begin
            failures++;
            $display("FAIL unexpected_event dut%0d cyc=%0d actual=%b required=none",
                     p, ecount, dut_o[p]);
          end else begin
            e = sbq[p].pop_front();
            if (e.val !== dut_o[p]) begin
              failures++;
              $display("FAIL event dut%0d cyc=%0d actual=%b required=%b",
                       p, ecount, dut_o[p], e.val);
            end
          end
        end
        last_st[p] = dut_o[p][1:0];
      end
    end
  end

  initial begin
    logic a, b;
    int len;
    bit found;
    model_reset();
    @(negedge clk);
    #1 check_quiet("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    repeat (20) step(1'b0, 1'b0);
    #1 check_quiet("idle_after_reset");

    // Single set press and release
    repeat (12) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);

    // Short clear glitch must be filtered
    repeat (3) step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);
    #1 check_quiet("after_glitch");

    // Simultaneous press: priority decides, conflict flagged
    repeat (10) step(1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b0);

    // Clear pressed while set is held: dropped, then a clean clear press
    repeat (10) step(1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);

    // Asynchronous reset while S is high
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step(1'b1, 1'b0);
      found = m_s_last[0];
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_for_S actual=timeout required=S_pulse");
    end else begin
      #1;
      checks++;
      if (s0 !== 1'b1 || s1 !== 1'b1) begin
        failures++;
        $display("FAIL pre_reset_S actual=%b%b required=11", s0, s1);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({s0, r0, s1, r1} !== 4'b0) begin
        failures++;
        $display("FAIL async_reset_SR actual=%b required=0000", {s0, r0, s1, r1});
      end
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (12) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);

    // Random button activity
    for (int k = 0; k < 80; k++) begin
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 10));
      repeat (len) step(a, b);
    end
    repeat (20) step(1'b0, 1'b0);

    for (int p = 0; p < 2; p++) begin
      checks++;
      if (sbq[p].size() != 0) begin
        failures++;
        $display("FAIL drain dut%0d actual=%0d pending required=0", p, sbq[p].size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
